secded_stream_decoder: RTL and testbench

Streaming receive-side decoder for the 40-bit padded Extended Hamming(13,8) codeword bus produced by the team's SECDED encoder. It accepts codewords over a valid/ready interface and corrects single-bit errors. It flags double and uncorrectable errors and returns data over a valid/ready interface. It sits at the consumer end of a link or memory read path and keeps saturating error statistics plus a sticky first-uncorrectable-error capture for software.

---
 rtl/secded_pkg.sv | 40 ++++
 rtl/secded_syndrome_calc.sv | 23 ++
 rtl/secded_stream_decoder.sv | 228 ++++++++++++++++++++++
 tb/tb_secded_stream_decoder.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/secded_pkg.sv
`default_nettype none
// ============================================================================
// Module      : secded_pkg
// Description : Shared definitions for the Extended Hamming(13,8) SECDED
//               encoder/decoder pair: codeword geometry, bit-position tables,
//               syndrome function and error classification enum.
// Revision    : 1.0 - initial release
// ============================================================================
package secded_pkg;

  // Codeword geometry
  localparam int c_N       = 13;  // codeword bits including overall parity
  localparam int c_K       = 8;   // payload bits
  localparam int c_OVR_IDX = 12;  // overall-parity bit index

  // Position tables, element [i] is the 0-based codeword index
  localparam logic [7:0][3:0] c_DATA_POS = {4'd11, 4'd10, 4'd9, 4'd8,
                                            4'd6,  4'd5,  4'd4, 4'd2};
  localparam logic [3:0][3:0] c_PAR_POS  = {4'd7, 4'd3, 4'd1, 4'd0};

  // Syndrome coverage masks over codeword bits [12:0]
  localparam logic [12:0] c_S0_MASK = 13'h0555;  // bits 0,2,4,6,8,10
  localparam logic [12:0] c_S1_MASK = 13'h0666;  // bits 1,2,5,6,9,10
  localparam logic [12:0] c_S2_MASK = 13'h0878;  // bits 3,4,5,6,11
  localparam logic [12:0] c_S3_MASK = 13'h0F80;  // bits 7..11

  typedef enum logic [1:0] {
    CLEAN  = 2'd0,
    CORR   = 2'd1,
    UNCORR = 2'd2
  } err_class_t;

  // Hamming syndrome; its value is the 1-based position of a single error
  function automatic logic [3:0] calc_syndrome(input logic [12:0] cw);
    calc_syndrome = {^(cw & c_S3_MASK), ^(cw & c_S2_MASK),
                     ^(cw & c_S1_MASK), ^(cw & c_S0_MASK)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/secded_syndrome_calc.sv
`default_nettype none
// ============================================================================
// Module      : secded_syndrome_calc
// Description : Combinational syndrome and overall-parity generator for one
//               13-bit Extended Hamming(13,8) codeword.
// Ports       : codeword [12:0] in  - received codeword
//               syndrome [3:0]  out - raw Hamming syndrome
//               pe              out - overall parity error (XOR of all bits)
// Revision    : 1.0 - initial release
// ============================================================================
module secded_syndrome_calc
  import secded_pkg::*;
(
  input  logic [c_N-1:0] codeword,
  output logic [3:0]     syndrome,
  output logic           pe
);

  assign syndrome = calc_syndrome(codeword);
  assign pe       = ^codeword;

endmodule
`default_nettype wire

// File: rtl/secded_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module      : secded_stream_decoder
// Description : Two-stage streaming SECDED decoder for the 40-bit padded
//               Extended Hamming(13,8) codeword bus. Corrects single errors,
//               flags uncorrectable beats, keeps saturating error counters
//               and a sticky capture of the first uncorrectable beat.
// Ports       : clk, rst_n (async, active-low)
//               s_valid/s_ready/s_codeword[39:0]/s_tag  - input stream
//               m_valid/m_ready/m_data/m_tag             - output stream
//               m_err_corr/m_err_uncorr/m_syndrome       - per-beat status
//               clr_counts                               - clear stats
//               corr_count/uncorr_count                  - saturating counts
//               first_err_valid/_tag/_syndrome           - sticky capture
// Config      : `define SECDED_PAD_CHECK_EN makes any nonzero padding bit in
//               s_codeword[39:13] mark the beat uncorrectable.
// Revision    : 1.0 - initial release
// ============================================================================
module secded_stream_decoder
  import secded_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int TAG_WIDTH  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [39:0]           s_codeword,
  input  logic [TAG_WIDTH-1:0]  s_tag,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [TAG_WIDTH-1:0]  m_tag,
  output logic                  m_err_corr,
  output logic                  m_err_uncorr,
  output logic [3:0]            m_syndrome,
  input  logic                  clr_counts,
  output logic [CNT_WIDTH-1:0]  corr_count,
  output logic [CNT_WIDTH-1:0]  uncorr_count,
  output logic                  first_err_valid,
  output logic [TAG_WIDTH-1:0]  first_err_tag,
  output logic [3:0]            first_err_syndrome
);

  if (DATA_WIDTH != c_K) begin : g_bad_width
    $error("secded_stream_decoder: DATA_WIDTH must be 8");
  end

  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;

  // Stage 1
  logic                 r_s1_valid;
  logic [c_N-1:0]       r_s1_cw;
  logic [TAG_WIDTH-1:0] r_s1_tag;
  logic [3:0]           r_s1_syn;
  logic                 r_s1_pe;
  logic [3:0]           w_syn;
  logic                 w_pe;

  // Stage 2 / outputs
  logic                  r_m_valid;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic [TAG_WIDTH-1:0]  r_m_tag;
  logic                  r_m_err_corr;
  logic                  r_m_err_uncorr;
  logic [3:0]            r_m_syn;

  // Statistics
  logic [CNT_WIDTH-1:0] r_corr_count;
  logic [CNT_WIDTH-1:0] r_uncorr_count;
  logic                 r_fe_valid;
  logic [TAG_WIDTH-1:0] r_fe_tag;
  logic [3:0]           r_fe_syn;

  logic                  w_s2_ready;
  logic                  w_accept;
  err_class_t            w_class;
  logic [c_N-1:0]        w_flip;
  logic [c_N-1:0]        w_fixed;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_unused_par;
  logic                  w_unused_pad;

  // Stage 2 can take a new beat when empty or when its beat leaves this cycle;
  // stage 1 advances exactly then, so it can also refill in the same cycle.
  assign w_s2_ready = !r_m_valid || m_ready;
  assign s_ready    = !r_s1_valid || w_s2_ready;
  assign w_accept   = r_m_valid && m_ready;

  secded_syndrome_calc u_syndrome_calc (
    .codeword (s_codeword[c_N-1:0]),
    .syndrome (w_syn),
    .pe       (w_pe)
  );

`ifdef SECDED_PAD_CHECK_EN
  logic r_s1_pad_err;
  assign w_unused_pad = 1'b0;
`else
  assign w_unused_pad = ^s_codeword[39:c_N];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_cw    <= '0;
      r_s1_tag   <= '0;
      r_s1_syn   <= '0;
      r_s1_pe    <= 1'b0;
`ifdef SECDED_PAD_CHECK_EN
      r_s1_pad_err <= 1'b0;
`endif
    end else if (s_ready) begin
      r_s1_valid <= s_valid;
      if (s_valid) begin
        r_s1_cw  <= s_codeword[c_N-1:0];
        r_s1_tag <= s_tag;
        r_s1_syn <= w_syn;
        r_s1_pe  <= w_pe;
`ifdef SECDED_PAD_CHECK_EN
        r_s1_pad_err <= |s_codeword[39:c_N];
`endif
      end
    end
  end

  // Classification and correction mask. A syndrome of 13..15 with odd parity
  // points outside the codeword, so it is treated as uncorrectable.
  always_comb begin
    w_class = CLEAN;
    w_flip  = '0;
    if (r_s1_pe) begin
      if (r_s1_syn == 4'd0) begin
        w_class            = CORR;
        w_flip[c_OVR_IDX]  = 1'b1;
      end else if (r_s1_syn <= 4'd12) begin
        w_class = CORR;
        for (int i = 0; i < c_N - 1; i++) begin
          if (r_s1_syn == 4'(i + 1)) w_flip[i] = 1'b1;
        end
      end else begin
        w_class = UNCORR;
      end
    end else if (r_s1_syn != 4'd0) begin
      w_class = UNCORR;
    end
`ifdef SECDED_PAD_CHECK_EN
    if (r_s1_pad_err) begin
      w_class = UNCORR;
      w_flip  = '0;
    end
`endif
  end

  assign w_fixed = r_s1_cw ^ w_flip;

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_data
    assign w_data[i] = w_fixed[c_DATA_POS[i]];
  end

  // Corrected parity bits are not forwarded downstream
  assign w_unused_par = ^{w_fixed[c_PAR_POS[0]], w_fixed[c_PAR_POS[1]],
                          w_fixed[c_PAR_POS[2]], w_fixed[c_PAR_POS[3]],
                          w_fixed[c_OVR_IDX]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid      <= 1'b0;
      r_m_data       <= '0;
      r_m_tag        <= '0;
      r_m_err_corr   <= 1'b0;
      r_m_err_uncorr <= 1'b0;
      r_m_syn        <= '0;
    end else if (w_s2_ready) begin
      r_m_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_m_data       <= w_data;
        r_m_tag        <= r_s1_tag;
        r_m_err_corr   <= (w_class == CORR);
        r_m_err_uncorr <= (w_class == UNCORR);
        r_m_syn        <= r_s1_syn;
      end
    end
  end

  // Statistics update on output acceptance; a clear drops same-cycle updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_corr_count   <= '0;
      r_uncorr_count <= '0;
      r_fe_valid     <= 1'b0;
      r_fe_tag       <= '0;
      r_fe_syn       <= '0;
    end else if (clr_counts) begin
      r_corr_count   <= '0;
      r_uncorr_count <= '0;
      r_fe_valid     <= 1'b0;
      r_fe_tag       <= '0;
      r_fe_syn       <= '0;
    end else if (w_accept) begin
      if (r_m_err_corr && (r_corr_count != c_CNT_MAX))
        r_corr_count <= r_corr_count + 1'b1;
      if (r_m_err_uncorr && (r_uncorr_count != c_CNT_MAX))
        r_uncorr_count <= r_uncorr_count + 1'b1;
      if (r_m_err_uncorr && !r_fe_valid) begin
        r_fe_valid <= 1'b1;
        r_fe_tag   <= r_m_tag;
        r_fe_syn   <= r_m_syn;
      end
    end
  end

  assign m_valid            = r_m_valid;
  assign m_data             = r_m_data;
  assign m_tag              = r_m_tag;
  assign m_err_corr         = r_m_err_corr;
  assign m_err_uncorr       = r_m_err_uncorr;
  assign m_syndrome         = r_m_syn;
  assign corr_count         = r_corr_count;
  assign uncorr_count       = r_uncorr_count;
  assign first_err_valid    = r_fe_valid;
  assign first_err_tag      = r_fe_tag;
  assign first_err_syndrome = r_fe_syn;

endmodule
`default_nettype wire

// File: tb/tb_secded_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_secded_stream_decoder
// Description : Scoreboard bench for secded_stream_decoder. Stimulus pushes
//               expected beats into a queue; a negedge monitor pops and
//               compares, and tracks counters/capture with its own model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_secded_stream_decoder;

  localparam int TAG_W = 4;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic [39:0]       s_codeword;
  logic [TAG_W-1:0]  s_tag;
  logic              m_valid;
  logic              m_ready;
  logic [7:0]        m_data;
  logic [TAG_W-1:0]  m_tag;
  logic              m_err_corr;
  logic              m_err_uncorr;
  logic [3:0]        m_syndrome;
  logic              clr_counts;
  logic [CNT_W-1:0]  corr_count;
  logic [CNT_W-1:0]  uncorr_count;
  logic              first_err_valid;
  logic [TAG_W-1:0]  first_err_tag;
  logic [3:0]        first_err_syndrome;

  secded_stream_decoder #(
    .DATA_WIDTH (8),
    .TAG_WIDTH  (TAG_W),
    .CNT_WIDTH  (CNT_W)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .s_valid            (s_valid),
    .s_ready            (s_ready),
    .s_codeword         (s_codeword),
    .s_tag              (s_tag),
    .m_valid            (m_valid),
    .m_ready            (m_ready),
    .m_data             (m_data),
    .m_tag              (m_tag),
    .m_err_corr         (m_err_corr),
    .m_err_uncorr       (m_err_uncorr),
    .m_syndrome         (m_syndrome),
    .clr_counts         (clr_counts),
    .corr_count         (corr_count),
    .uncorr_count       (uncorr_count),
    .first_err_valid    (first_err_valid),
    .first_err_tag      (first_err_tag),
    .first_err_syndrome (first_err_syndrome)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]       data;
    logic [TAG_W-1:0] tag;
    logic             corr;
    logic             uncorr;
    logic [3:0]       syn;
    bit               chk_lat;
    int               acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   rand_ready = 0;
  logic ready_level = 1'b1;

  // Monitor-owned statistics model
  int               mc_corr = 0;
  int               mc_uncorr = 0;
  bit               mc_fe_valid = 0;
  logic [TAG_W-1:0] mc_fe_tag = '0;
  logic [3:0]       mc_fe_syn = '0;
  bit               prev_stall = 0;
  logic [18:0]      held = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: data occupies the 1-based positions that are not powers of two
  function automatic logic [12:0] encode(input logic [7:0] d);
    logic [12:0] w;
    int k, syn;
    w = '0; k = 0; syn = 0;
    for (int p = 1; p <= 12; p++) begin
      if ((p & (p - 1)) != 0) begin
        w[p-1] = d[k];
        if (d[k]) syn ^= p;
        k++;
      end
    end
    for (int j = 0; j < 4; j++)
      if (((syn >> j) & 1) != 0) w[(1 << j) - 1] = 1'b1;
    w[12] = ^w[11:0];
    return w;
  endfunction

  function automatic exp_t model(input logic [39:0] cw, input logic [TAG_W-1:0] tag);
    exp_t e;
    logic [12:0] w;
    int syn, ones, k;
    w = cw[12:0]; syn = 0; ones = 0;
    for (int i = 0; i < 13; i++) begin
      if (w[i]) begin
        ones++;
        if (i < 12) syn ^= (i + 1);
      end
    end
    e.corr = 0; e.uncorr = 0;
    if ((ones % 2) == 1) begin
      if (syn == 0) e.corr = 1;
      else if (syn <= 12) begin e.corr = 1; w[syn-1] = ~w[syn-1]; end
      else e.uncorr = 1;
    end else if (syn != 0) e.uncorr = 1;
    k = 0;
    for (int p = 1; p <= 12; p++) begin
      if ((p & (p - 1)) != 0) begin e.data[k] = w[p-1]; k++; end
    end
    e.syn = 4'(syn);
    e.tag = tag;
    e.chk_lat = 0;
    e.acc_cyc = 0;
    return e;
  endfunction

  task automatic send(input logic [39:0] cw, input logic [TAG_W-1:0] tag,
                      input exp_t e_in);
    exp_t e;
    bit acc;
    int guard, acyc;
    e = e_in;
    s_codeword = cw; s_tag = tag; s_valid = 1'b1;
    acc = 0; guard = 0; acyc = 0;
    forever begin
      @(negedge clk);
      acc = s_ready; acyc = cyc;
      @(posedge clk);
      if (acc) break;
      guard++;
      if (guard > 200) begin chk("send_timeout", 1, 0); break; end
    end
    if (acc) begin
      e.tag = tag; e.acc_cyc = acyc;
      exp_q.push_back(e);
    end
    #1 s_valid = 1'b0;
  endtask

  task automatic send_lit(input logic [39:0] cw, input logic [TAG_W-1:0] tag,
                          input logic [7:0] d, input logic c, input logic u,
                          input logic [3:0] syn);
    exp_t e;
    e.data = d; e.tag = tag; e.corr = c; e.uncorr = u; e.syn = syn;
    e.chk_lat = 1; e.acc_cyc = 0;
    send(cw, tag, e);
  endtask

  task automatic send_rand(input int nerr, input bit pad);
    logic [39:0] cw;
    logic [TAG_W-1:0] tag;
    int pos[$];
    int p;
    cw = '0;
    cw[12:0] = encode(8'($urandom_range(0, 255)));
    if (pad) cw[39:13] = 27'($urandom);
    while (pos.size() < nerr) begin
      p = $urandom_range(0, 12);
      if (!(p inside {pos})) pos.push_back(p);
    end
    foreach (pos[i]) cw[pos[i]] = ~cw[pos[i]];
    tag = TAG_W'($urandom_range(0, 15));
    send(cw, tag, model(cw, tag));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin @(posedge clk); guard++; end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 0);
    #1;
  endtask

  task automatic pulse_clr();
    clr_counts = 1'b1;
    @(posedge clk); #1;
    clr_counts = 1'b0;
  endtask

  // m_ready driver
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    bit popped;
    popped = 0;
    if (!rst_n) begin
      chk("rst_m_valid", 64'(m_valid), 0);
      mc_corr = 0; mc_uncorr = 0; mc_fe_valid = 0; mc_fe_tag = '0; mc_fe_syn = '0;
      prev_stall = 0;
    end else begin
      chk("s_ready", 64'(s_ready), 64'((exp_q.size() < 2) || m_ready));
      if (prev_stall)
        chk("stall_hold", {45'd0, m_valid, m_data, m_tag, m_err_corr, m_err_uncorr, m_syndrome},
            {45'd0, held});
      if (m_valid) begin
        if (exp_q.size() == 0) chk("spurious_beat", 1, 0);
        else if (m_ready) begin
          e = exp_q.pop_front();
          popped = 1;
          chk("beat_data", 64'(m_data), 64'(e.data));
          chk("beat_tag", 64'(m_tag), 64'(e.tag));
          chk("beat_flags", 64'({m_err_corr, m_err_uncorr}), 64'({e.corr, e.uncorr}));
          chk("beat_syndrome", 64'(m_syndrome), 64'(e.syn));
          if (e.chk_lat) chk("latency", 64'(cyc), 64'(e.acc_cyc + 2));
        end
      end
      prev_stall = m_valid && !m_ready;
      held = {m_valid, m_data, m_tag, m_err_corr, m_err_uncorr, m_syndrome};
      chk("corr_count", 64'(corr_count), 64'(mc_corr));
      chk("uncorr_count", 64'(uncorr_count), 64'(mc_uncorr));
      chk("capture", {51'd0, first_err_valid, first_err_tag, first_err_syndrome},
          {51'd0, mc_fe_valid, mc_fe_tag, mc_fe_syn});
      if (clr_counts) begin
        mc_corr = 0; mc_uncorr = 0; mc_fe_valid = 0; mc_fe_tag = '0; mc_fe_syn = '0;
      end else if (popped) begin
        if (e.corr && mc_corr < CMAX) mc_corr++;
        if (e.uncorr && mc_uncorr < CMAX) mc_uncorr++;
        if (e.uncorr && !mc_fe_valid) begin
          mc_fe_valid = 1; mc_fe_tag = e.tag; mc_fe_syn = e.syn;
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $finish;
  end

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_codeword = '0; s_tag = '0; clr_counts = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_m_valid", 64'(m_valid), 0);
    chk("reset_s_ready", 64'(s_ready), 1);
    chk("reset_outputs", {46'd0, m_data, m_tag, m_err_corr, m_err_uncorr, m_syndrome}, 0);
    chk("reset_stats", {49'd0, corr_count, uncorr_count, first_err_valid, first_err_tag,
                        first_err_syndrome}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Directed beats with literal expectations
    send_lit(40'h0000000F77, 4'h1, 8'hFF, 1'b0, 1'b0, 4'd0);
    send_lit(40'h0000000F57, 4'h2, 8'hFF, 1'b1, 1'b0, 4'd6);
    send_lit(40'h0000001F77, 4'h0, 8'hFF, 1'b1, 1'b0, 4'd0);
    send_lit(40'h0000000D57, 4'h3, 8'hDB, 1'b0, 1'b1, 4'd12);
    send_lit(40'h0000000FFE, 4'h5, 8'hFF, 1'b0, 1'b1, 4'd13);
    drain();
    idle(1);
    chk("dir_corr_count", 64'(corr_count), 2);
    chk("dir_uncorr_count", 64'(uncorr_count), 2);
    chk("dir_capture", {56'd0, first_err_valid, 1'b0, first_err_tag, first_err_syndrome},
        {56'd0, 1'b1, 1'b0, 4'h3, 4'd12});
    pulse_clr();
    chk("clr_stats", {49'd0, corr_count, uncorr_count, first_err_valid, first_err_tag,
                      first_err_syndrome}, 0);

    // Back-to-back burst under random backpressure
    rand_ready = 1;
    for (int i = 0; i < 8; i++) send_rand($urandom_range(0, 2), 1'b0);
    drain();

    // Randomized traffic with padding noise, gaps and occasional clears
    for (int i = 0; i < 200; i++) begin
      send_rand($urandom_range(0, 3), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 24) == 0) pulse_clr();
    end
    drain();
    rand_ready = 0; ready_level = 1'b1;
    idle(2);

    // Saturation
    pulse_clr();
    for (int i = 0; i < 5; i++) send_rand(1, 1'b0);
    drain();
    idle(1);
    chk("sat_corr_count", 64'(corr_count), 3);

    // Reset with beats in flight
    ready_level = 1'b0;
    idle(1);
    send_rand(0, 1'b0);
    send_rand(1, 1'b0);
    idle(1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_m_valid", 64'(m_valid), 0);
    idle(2);
    rst_n = 1'b1;
    ready_level = 1'b1;
    idle(10);
    chk("post_rst_counts", {62'd0, corr_count}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
